// File: rtl/shr_scan_sequencer.sv
// ---------------------------------------------------------------------------
// shr_scan_sequencer
//
// Deterministic, abortable frame controller for a serial shift-register chain.
// One frame is a SYNC preamble (syn high), NBITS data bits clocked out MSB
// first on din/clk, and a quiet tail period. The chain's serial return (dout)
// is sampled on every serial-clock rising edge and the assembled frame is
// published in cap_reg once the frame completes.
//
// Ports:
//   clk_in   - system clock, the only clock of this block
//   rst      - synchronous, active-high reset
//   trig     - start request (level; rising edge starts a frame)
//   dump     - abort request (level; rising edge aborts a running frame)
//   data_reg - pattern to shift out, MSB first
//   dout     - serial return from the chain
//   clk      - serial clock to the chain
//   din      - serial data to the chain
//   syn      - frame sync to the chain
//   busy     - high whenever a frame is in progress
//   done     - one-cycle pulse when a frame completes
//   aborted  - one-cycle pulse when a frame is aborted
//   cap_reg  - last completed captured frame (first captured bit in the MSB)
//   bit_cnt  - number of bits shifted in the current/last frame
//
// Every output is a flop; no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module shr_scan_sequencer #(
   parameter int NBITS    = 491,
   parameter int DIV      = 4,
   parameter int SYNC_LEN = 2,
   parameter int CW       = 9
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             trig,
   input  logic             dump,
   input  logic [NBITS-1:0] data_reg,
   input  logic             dout,
   output logic             clk,
   output logic             din,
   output logic             syn,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [NBITS-1:0] cap_reg,
   output logic [CW-1:0]    bit_cnt
);

   // Divider counts clk_in cycles within one serial half period.
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   // Half-period counter covers the SYNC preamble (2*SYNC_LEN halves) and
   // the two halves of the tail.
   localparam int HW = (2 * SYNC_LEN > 2) ? $clog2(2 * SYNC_LEN) : 1;

   localparam logic [DW-1:0] DIV_LAST       = DW'(DIV - 1);
   localparam logic [HW-1:0] SYNC_HALF_LAST = HW'(2 * SYNC_LEN - 1);
   localparam logic [HW-1:0] TAIL_HALF_LAST = HW'(1);
   localparam logic [CW-1:0] BIT_LAST       = CW'(NBITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SYNC  = 2'd1,
      SHIFT = 2'd2,
      TAIL  = 2'd3
   } state_t;

   state_t           state;
   logic [DW-1:0]    div_cnt;
   logic [HW-1:0]    half_cnt;
   logic             phase_hi;
   logic [NBITS-1:0] sh;
   logic [NBITS-1:0] cap_sh;

   logic             trig_q;
   logic             trig_prev;
   logic             dump_q;
   logic             dump_prev;
   logic             trig_edge;
   logic             dump_edge;

   // Requests are registered once and compared with their previous sample,
   // so a level held high produces exactly one edge.
   assign trig_edge = trig_q & ~trig_prev;
   assign dump_edge = dump_q & ~dump_prev;

   // Single frame controller. Outputs are assigned together with the state
   // transition so that they describe the cycle being entered; this keeps
   // every output registered while still lining up with the state.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state     <= IDLE;
         div_cnt   <= '0;
         half_cnt  <= '0;
         phase_hi  <= 1'b0;
         sh        <= '0;
         cap_sh    <= '0;
         trig_q    <= 1'b0;
         trig_prev <= 1'b0;
         dump_q    <= 1'b0;
         dump_prev <= 1'b0;
         clk       <= 1'b0;
         din       <= 1'b0;
         syn       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
         cap_reg   <= '0;
         bit_cnt   <= '0;
      end else begin
         trig_q    <= trig;
         trig_prev <= trig_q;
         dump_q    <= dump;
         dump_prev <= dump_q;
         done      <= 1'b0;
         aborted   <= 1'b0;

         if (state != IDLE && dump_edge) begin
            // Abort wins over any progress in the same cycle; the partial
            // capture is dropped and bit_cnt keeps its value.
            state    <= IDLE;
            div_cnt  <= '0;
            half_cnt <= '0;
            phase_hi <= 1'b0;
            clk      <= 1'b0;
            din      <= 1'b0;
            syn      <= 1'b0;
            busy     <= 1'b0;
            aborted  <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  // A start coinciding with an abort request is ignored.
                  if (trig_edge && !dump_edge) begin
                     state    <= SYNC;
                     sh       <= data_reg;
                     cap_sh   <= '0;
                     bit_cnt  <= '0;
                     div_cnt  <= '0;
                     half_cnt <= '0;
                     phase_hi <= 1'b0;
                     busy     <= 1'b1;
                     syn      <= 1'b1;
                     clk      <= 1'b0;
                     din      <= data_reg[NBITS-1];
                  end
               end

               SYNC: begin
                  din <= sh[NBITS-1];
                  if (div_cnt == DIV_LAST) begin
                     div_cnt <= '0;
                     if (half_cnt == SYNC_HALF_LAST) begin
                        state    <= SHIFT;
                        half_cnt <= '0;
                        phase_hi <= 1'b0;
                        syn      <= 1'b0;
                     end else begin
                        half_cnt <= half_cnt + HW'(1);
                     end
                  end else begin
                     div_cnt <= div_cnt + DW'(1);
                  end
               end

               SHIFT: begin
                  // dout is taken in the first cycle after the serial clock
                  // rises, giving the chain a full clk_in cycle to settle.
                  if (phase_hi && div_cnt == '0) begin
                     cap_sh <= {cap_sh[NBITS-2:0], dout};
                  end
                  if (div_cnt == DIV_LAST) begin
                     div_cnt <= '0;
                     if (!phase_hi) begin
                        phase_hi <= 1'b1;
                        clk      <= 1'b1;
                     end else begin
                        // End of a bit: advance the pattern and the count.
                        phase_hi <= 1'b0;
                        clk      <= 1'b0;
                        sh       <= {sh[NBITS-2:0], 1'b0};
                        bit_cnt  <= bit_cnt + CW'(1);
                        if (bit_cnt == BIT_LAST) begin
                           state    <= TAIL;
                           half_cnt <= '0;
                           din      <= 1'b0;
                        end else begin
                           din <= sh[NBITS-2];
                        end
                     end
                  end else begin
                     div_cnt <= div_cnt + DW'(1);
                  end
               end

               TAIL: begin
                  if (div_cnt == DIV_LAST) begin
                     div_cnt <= '0;
                     if (half_cnt == TAIL_HALF_LAST) begin
                        // Publish the frame; busy falls as done rises.
                        state    <= IDLE;
                        half_cnt <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cap_reg  <= cap_sh;
                     end else begin
                        half_cnt <= half_cnt + HW'(1);
                     end
                  end else begin
                     div_cnt <= div_cnt + DW'(1);
                  end
               end

               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  clk   <= 1'b0;
                  din   <= 1'b0;
                  syn   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_shr_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shr_scan_sequencer
//
// Drives a small instance (NBITS=8, DIV=2, SYNC_LEN=1) against a frame-offset
// reference model, with directed scenarios plus randomized frames, and runs
// one full frame on a default-parameter instance with a walking-one pattern.
// ---------------------------------------------------------------------------
module tb_shr_scan_sequencer;

   localparam int N         = 8;
   localparam int D         = 2;
   localparam int SL        = 1;
   localparam int CWS       = 4;
   localparam int SYNC_CYC  = 2 * D * SL;
   localparam int SHIFT_END = SYNC_CYC + 2 * D * N;
   localparam int FRAME_CYC = SHIFT_END + 2 * D;

   localparam int NB  = 491;
   localparam int CWB = 9;

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   // Small instance
   logic           rst, trig, dump, loop_en, dout_val, dout;
   logic [N-1:0]   data_reg;
   logic           s_clk, s_din, s_syn, s_busy, s_done, s_aborted;
   logic [N-1:0]   s_cap;
   logic [CWS-1:0] s_cnt;

   assign dout = loop_en ? s_din : dout_val;

   shr_scan_sequencer #(.NBITS(N), .DIV(D), .SYNC_LEN(SL), .CW(CWS)) dut (
      .clk_in(clk_in), .rst(rst), .trig(trig), .dump(dump),
      .data_reg(data_reg), .dout(dout),
      .clk(s_clk), .din(s_din), .syn(s_syn), .busy(s_busy),
      .done(s_done), .aborted(s_aborted), .cap_reg(s_cap), .bit_cnt(s_cnt)
   );

   // Default-parameter instance, dout looped back to din
   logic           trig_b;
   logic [NB-1:0]  data_b;
   logic           b_clk, b_din, b_syn, b_busy, b_done, b_aborted;
   logic [NB-1:0]  b_cap;
   logic [CWB-1:0] b_cnt;

   shr_scan_sequencer dut_big (
      .clk_in(clk_in), .rst(rst), .trig(trig_b), .dump(1'b0),
      .data_reg(data_b), .dout(b_din),
      .clk(b_clk), .din(b_din), .syn(b_syn), .busy(b_busy),
      .done(b_done), .aborted(b_aborted), .cap_reg(b_cap), .bit_cnt(b_cnt)
   );

   // Reference model: a frame is a run of FRAME_CYC cycles indexed by m_k;
   // outputs are derived from that offset arithmetically.
   logic         m_active = 1'b0, m_done = 1'b0, m_abort = 1'b0;
   int           m_k = 0, m_cnt = 0;
   logic [N-1:0] m_pat = '0, m_capt = '0, m_cap = '0;
   logic         h_tq = 1'b0, h_tp = 1'b0, h_dq = 1'b0, h_dp = 1'b0;

   always @(posedge clk_in) begin
      logic te, de;
      int   ph;
      if (rst) begin
         m_active = 1'b0; m_done = 1'b0; m_abort = 1'b0;
         m_k = 0; m_cnt = 0; m_pat = '0; m_capt = '0; m_cap = '0;
         h_tq = 1'b0; h_tp = 1'b0; h_dq = 1'b0; h_dp = 1'b0;
      end else begin
         te = h_tq && !h_tp;
         de = h_dq && !h_dp;
         m_done = 1'b0;
         m_abort = 1'b0;
         if (m_active) begin
            if (de) begin
               m_active = 1'b0;
               m_abort = 1'b1;
            end else begin
               if (m_k >= SYNC_CYC && m_k < SHIFT_END) begin
                  ph = (m_k - SYNC_CYC) % (2 * D);
                  if (ph == D) m_capt = {m_capt[N-2:0], dout};
                  if (ph == 2 * D - 1) m_cnt = m_cnt + 1;
               end
               if (m_k == FRAME_CYC - 1) begin
                  m_active = 1'b0;
                  m_done = 1'b1;
                  m_cap = m_capt;
               end else begin
                  m_k = m_k + 1;
               end
            end
         end else if (te && !de) begin
            m_active = 1'b1; m_k = 0; m_pat = data_reg; m_capt = '0; m_cnt = 0;
         end
         h_tp = h_tq; h_tq = trig;
         h_dp = h_dq; h_dq = dump;
      end
   end

   int   total = 0, bad = 0;
   logic chk_en = 1'b0;

   // Observed-waveform statistics for the hand-computed checks
   int           syn_cyc = 0, clk_rises = 0, busy_rises = 0, done_cnt = 0, abort_cnt = 0;
   int           busy_cyc = 0, done_cyc = 0;
   logic [N-1:0] din_seq = '0;
   logic         prev_clk = 1'b0, prev_busy = 1'b0;

   task automatic checkOutput(input string name, input logic [511:0] got, input logic [511:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input logic t, input logic d, input logic [N-1:0] data,
                                input logic lp, input logic dv);
      trig = t; dump = d; data_reg = data; loop_en = lp; dout_val = dv;
   endtask

   // One clock: sample at the falling edge, compare against the model,
   // and update the waveform statistics.
   task automatic step();
      logic e_clk, e_din, e_syn;
      int   j;
      @(negedge clk_in);
      if (chk_en) begin
         e_clk = 1'b0; e_din = 1'b0; e_syn = 1'b0;
         if (m_active) begin
            if (m_k < SYNC_CYC) begin
               e_syn = 1'b1;
               e_din = m_pat[N-1];
            end else if (m_k < SHIFT_END) begin
               j = m_k - SYNC_CYC;
               e_clk = (j % (2 * D)) >= D;
               e_din = m_pat[N - 1 - j / (2 * D)];
            end
         end
         checkOutput("clk", s_clk, e_clk);
         checkOutput("din", s_din, e_din);
         checkOutput("syn", s_syn, e_syn);
         checkOutput("busy", s_busy, m_active);
         checkOutput("done", s_done, m_done);
         checkOutput("aborted", s_aborted, m_abort);
         checkOutput("cap_reg", s_cap, m_cap);
         checkOutput("bit_cnt", s_cnt, m_cnt[CWS-1:0]);
      end
      if (s_syn) syn_cyc++;
      if (s_clk && !prev_clk) begin
         clk_rises++;
         din_seq = {din_seq[N-2:0], s_din};
      end
      if (s_busy && !prev_busy) begin
         busy_rises++;
         busy_cyc = cyc;
      end
      if (s_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (s_aborted) abort_cnt++;
      prev_clk = s_clk;
      prev_busy = s_busy;
   endtask

   task automatic start_frame(input logic [N-1:0] d, input logic lp, input logic dv);
      applyStimulus(1'b0, 1'b0, d, lp, dv);
      step(); step();
      applyStimulus(1'b1, 1'b0, d, lp, dv);
      step();
   endtask

   task automatic wait_end(input int bound);
      int n = 0;
      while (!s_done && !s_aborted && n < bound) begin
         step();
         n++;
      end
      checkOutput("frame_end_timeout", n >= bound, 1'b0);
   endtask

   task automatic wait_rises(input int target);
      int n = 0;
      while (clk_rises < target && n < 200) begin
         step();
         n++;
      end
      checkOutput("clk_rise_timeout", n >= 200, 1'b0);
   endtask

   initial begin
      int           s0, s1, s2, s3, n, ab;
      logic [N-1:0] d;
      logic         lp;
      int           pos;

      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
      trig_b = 1'b0;
      data_b = '0;
      rst = 1'b1;
      @(negedge clk_in);
      @(negedge clk_in);
      chk_en = 1'b1;
      step();
      checkOutput("reset_busy", s_busy, 1'b0);
      checkOutput("reset_cap", s_cap, '0);
      checkOutput("reset_bit_cnt", s_cnt, '0);
      rst = 1'b0;
      step(); step();

      // A5 looped back
      $display("[TB] frame with 8'hA5, dout looped to din");
      s0 = syn_cyc; s1 = done_cnt;
      start_frame(8'hA5, 1'b1, 1'b0);
      wait_end(100);
      checkOutput("a5_syn_cycles", syn_cyc - s0, 4);
      checkOutput("a5_din_sequence", din_seq, 8'hA5);
      checkOutput("a5_done_delay", done_cyc - busy_cyc, 40);
      checkOutput("a5_busy_at_done", s_busy, 1'b0);
      checkOutput("a5_cap", s_cap, 8'hA5);
      checkOutput("a5_bit_cnt", s_cnt, 4'd8);
      step();
      checkOutput("a5_done_pulses", done_cnt - s1, 1);

      // dout tied high, then low
      start_frame(8'h00, 1'b0, 1'b1);
      wait_end(100);
      checkOutput("ones_cap", s_cap, 8'hFF);
      checkOutput("ones_bit_cnt", s_cnt, 4'd8);
      start_frame(8'h00, 1'b0, 1'b0);
      wait_end(100);
      checkOutput("zeros_cap", s_cap, 8'h00);
      checkOutput("zeros_bit_cnt", s_cnt, 4'd8);

      // Abort after the third serial clock pulse
      start_frame(8'h3C, 1'b1, 1'b0);
      wait_end(100);
      checkOutput("pre_abort_cap", s_cap, 8'h3C);
      d = 8'($urandom);
      s0 = done_cnt; s1 = abort_cnt;
      start_frame(d, 1'b1, 1'b0);
      wait_rises(clk_rises + 3);
      n = 0;
      while (s_clk && n < 20) begin step(); n++; end
      applyStimulus(1'b1, 1'b1, d, 1'b1, 1'b0);
      wait_end(20);
      checkOutput("abort_pulse", s_aborted, 1'b1);
      checkOutput("abort_clk", s_clk, 1'b0);
      checkOutput("abort_din", s_din, 1'b0);
      checkOutput("abort_syn", s_syn, 1'b0);
      checkOutput("abort_cap_kept", s_cap, 8'h3C);
      checkOutput("abort_bit_cnt", s_cnt, 4'd3);
      repeat (60) step();
      checkOutput("abort_no_done", done_cnt - s0, 0);
      checkOutput("abort_pulses", abort_cnt - s1, 1);

      // trig held high across two frame lengths
      s0 = busy_rises; s1 = done_cnt;
      start_frame(8'h5A, 1'b1, 1'b0);
      repeat (100) step();
      checkOutput("held_trig_frames", busy_rises - s0, 1);
      checkOutput("held_trig_done", done_cnt - s1, 1);

      // Re-edge on trig while busy is ignored
      s0 = busy_rises; s1 = done_cnt;
      start_frame(8'hC3, 1'b1, 1'b0);
      repeat (10) step();
      applyStimulus(1'b0, 1'b0, 8'hC3, 1'b1, 1'b0);
      repeat (3) step();
      applyStimulus(1'b1, 1'b0, 8'hC3, 1'b1, 1'b0);
      repeat (80) step();
      checkOutput("reedge_frames", busy_rises - s0, 1);
      checkOutput("reedge_done", done_cnt - s1, 1);

      // Simultaneous trig and dump edges in IDLE
      s0 = busy_rises; s1 = abort_cnt;
      applyStimulus(1'b0, 1'b0, 8'h81, 1'b1, 1'b0);
      repeat (3) step();
      applyStimulus(1'b1, 1'b1, 8'h81, 1'b1, 1'b0);
      repeat (10) step();
      checkOutput("simul_edges_busy", busy_rises - s0, 0);
      checkOutput("simul_edges_abort", abort_cnt - s1, 0);

      // Reset in the middle of SHIFT
      d = 8'($urandom);
      start_frame(d, 1'b1, 1'b0);
      wait_rises(clk_rises + 3);
      applyStimulus(1'b0, 1'b0, d, 1'b1, 1'b0);
      rst = 1'b1;
      step();
      checkOutput("midrst_outputs", {s_clk, s_din, s_syn, s_busy, s_done, s_aborted}, 6'b0);
      checkOutput("midrst_cap", s_cap, 8'h00);
      checkOutput("midrst_bit_cnt", s_cnt, 4'd0);
      rst = 1'b0;
      d = 8'($urandom);
      start_frame(d, 1'b1, 1'b0);
      wait_end(100);
      checkOutput("post_rst_cap", s_cap, d);
      checkOutput("post_rst_bit_cnt", s_cnt, 4'd8);

      // Randomized frames: random data, dout source, trig jitter, aborts
      $display("[TB] randomized frames");
      for (int it = 0; it < 25; it++) begin
         d = 8'($urandom);
         lp = 1'($urandom_range(0, 1));
         ab = $urandom_range(0, 80);
         applyStimulus(1'b0, 1'($urandom_range(0, 1)), d, lp, 1'($urandom_range(0, 1)));
         step(); step();
         applyStimulus(1'b1, 1'b0, d, lp, dout_val);
         for (int c = 0; c < 60; c++) begin
            step();
            applyStimulus($urandom_range(0, 7) != 0, c == ab, d, lp, 1'($urandom_range(0, 1)));
         end
      end
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
      repeat (60) step();

      // Default-parameter frame with a walking one
      $display("[TB] default-parameter frame");
      pos = $urandom_range(0, NB - 1);
      data_b = '0;
      data_b[pos] = 1'b1;
      step();
      trig_b = 1'b1;
      step();
      checkOutput("big_busy_t0", b_busy, 1'b0);
      step();
      checkOutput("big_busy_t1", b_busy, 1'b1);
      s2 = cyc;
      n = 0;
      while (!b_done && n < 5000) begin step(); n++; end
      checkOutput("big_done_timeout", n >= 5000, 1'b0);
      checkOutput("big_done_delay", cyc - s2, 3952);
      checkOutput("big_busy_at_done", b_busy, 1'b0);
      checkOutput("big_cap", b_cap, data_b);
      checkOutput("big_bit_cnt", b_cnt, 9'd491);
      s3 = 0;
      repeat (20) begin
         step();
         if (b_done) s3++;
      end
      checkOutput("big_single_done", s3, 0);
      trig_b = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shr_scan_sequencer.md
Name: shr_scan_sequencer

Overview:
- Sequences one serial scan frame into the shift-register chain under test: SYNC preamble, then NBITS bits on din/clk, then a tail period.
- Samples dout on every serial clock rising edge and assembles the captured frame in a parallel register that the JTAG readout path can read.
- Sits between the vJTAG-loaded pattern register and the GPIO pins, replacing free-running trigger logic with a deterministic, abortable frame controller.

Parameters:
- NBITS, 491, frame length in bits; also the width of the pattern and capture registers.
- DIV, 4, clk_in cycles per serial-clock half period; must be >= 2.
- SYNC_LEN, 2, length of the syn preamble in serial periods; must be >= 1.
- CW, 9, width of bit_cnt; must satisfy 2^CW > NBITS.

Ports:
- clk_in  in  1  system clock (PLL output); the block's only clock.
- rst  in  1  synchronous, active-high reset.
- trig  in  1  start request, level; a rising edge starts a frame.
- dump  in  1  abort request, level; a rising edge aborts the frame in progress.
- data_reg  in  NBITS  pattern to shift out, MSB first.
- dout  in  1  serial return from the chain.
- clk  out  1  serial clock to the chain.
- din  out  1  serial data to the chain.
- syn  out  1  frame sync to the chain.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a frame completes.
- aborted  out  1  one-cycle pulse when a frame is aborted.
- cap_reg  out  NBITS  last completed captured frame.
- bit_cnt  out  CW  number of bits shifted in the current frame.

Behaviour:
- Reset (synchronous, active-high, takes effect at the clk_in edge where rst=1):
  - state=IDLE; clk, din, syn, busy, done, aborted = 0; cap_reg=0; bit_cnt=0; internal shift and capture shadows = 0; edge-detect history = 0.
  - Reset mid-frame behaves identically; a partial capture is discarded.
- Edge detect: trig and dump are registered once; an edge is cur=1 and prev=0. Levels held high generate no further edges.
- Timing base: div_cnt counts 0..DIV-1 in non-IDLE states and clears on every state entry. A half-tick occurs when div_cnt=DIV-1.
- IDLE:
  - Outputs low.
  - A trig edge with no dump edge in the same cycle loads data_reg into the shift shadow sh, clears the capture shadow and bit_cnt, and moves to SYNC at the next cycle.
  - A trig edge coinciding with a dump edge is ignored.
  - A dump edge in IDLE does nothing; aborted is not pulsed.
- SYNC:
  - syn=1, clk=0, din=sh[NBITS-1].
  - Lasts exactly 2*DIV*SYNC_LEN cycles, then moves to SHIFT.
- SHIFT, per bit, 2*DIV cycles:
  - Low half (DIV cycles): clk=0, din=sh[NBITS-1], syn=0.
  - High half (DIV cycles): clk=1, din unchanged.
  - In the first cycle of the high half, dout is sampled into the capture shadow LSB; the shadow shifts left.
  - At the last cycle of the high half: sh shifts left with 0 fill and bit_cnt increments.
  - When bit_cnt reaches NBITS, move to TAIL.
- TAIL:
  - clk=0, din=0, syn=0 for 2*DIV cycles.
  - Then copy the capture shadow to cap_reg, pulse done for 1 cycle, and return to IDLE. busy drops in the same cycle done is high.
- Abort: a dump edge in SYNC, SHIFT or TAIL returns to IDLE at the next cycle.
  - clk, din, syn go to 0 immediately on that transition.
  - aborted pulses for 1 cycle; cap_reg is unchanged; bit_cnt holds its value until the next start.
- While busy, trig edges are ignored and are not queued.
- Latency: trig edge detected at cycle t gives busy=1 at t+1 and done=1 at t+1+2*DIV*(SYNC_LEN+NBITS+1).
- First captured bit is cap_reg[NBITS-1]; the last captured bit is cap_reg[0].
- All outputs are registered; the block contains no combinational path from an input to an output.

Test Plan:
- Bench config NBITS=8, DIV=2, SYNC_LEN=1. data_reg=8'hA5, dout looped to din -> syn high for 4 cycles; 8 clk pulses with din sequence 1,0,1,0,0,1,0,1; done is a single pulse 40 cycles after busy rises; cap_reg=8'hA5.
- dout tied to 1, data_reg=8'h00 -> cap_reg=8'hFF. A second frame with dout tied to 0 -> cap_reg=8'h00. bit_cnt=8 after each frame.
- dump edge after the 3rd clk rising edge of a frame that started with cap_reg=8'h3C -> clk/din/syn=0 on the next cycle, aborted pulses once, no done pulse, cap_reg stays 8'h3C, bit_cnt=3.
- trig held high across two frame lengths -> exactly one frame runs. A trig re-edge while busy produces no second frame. Simultaneous trig and dump edges in IDLE -> busy stays 0.
- rst asserted mid-SHIFT -> on the next cycle every output is 0 and cap_reg=0. A following trig edge runs a clean full frame.
- Default parameters (NBITS=491, DIV=4, SYNC_LEN=2) with a walking-one pattern in data_reg and dout=din -> done at t+1+3952 cycles and cap_reg equals data_reg.
